// File: rtl/score_bitmap_writer_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score bitmap writer:
//   - string/glyph geometry constants (DIGITS, GLYPH_W, GLYPH_H, STRING_W,
//     GLYPH_SIZE) and the derived pixel count
//   - the saturation limit applied to the incoming binary score
//   - the render FSM state encoding
//   - helpers: double-dabble nibble adjust, font ROM address composition
// No ports (package).
// -----------------------------------------------------------------------------
package score_pkg;

  localparam int DIGITS     = 5;
  localparam int GLYPH_W    = 24;
  localparam int GLYPH_H    = 48;
  localparam int STRING_W   = 120;
  localparam int GLYPH_SIZE = 1152;
  localparam int PIXELS     = STRING_W * GLYPH_H;

  localparam int          SCORE_W   = 17;
  localparam int          BCD_W     = 20;
  localparam logic [16:0] SCORE_MAX = 17'd99999;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_DRAW    = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
    logic [19:0] res;
    res = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

  // Font ROM address: digit * GLYPH_SIZE + gy * GLYPH_W + gx.
  function automatic logic [13:0] glyph_addr(input logic [3:0] dv,
                                             input logic [5:0] gy,
                                             input logic [4:0] gx);
    return (14'(GLYPH_SIZE) * {10'd0, dv})
         + (14'(GLYPH_W) * {8'd0, gy})
         + {9'd0, gx};
  endfunction

endpackage

// File: rtl/score_bitmap_writer_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one input bit per cycle.
// The first bit is consumed in the same edge that accepts i_start (the BCD
// register is all-zero at that point, so no adjust is needed), the remaining
// 16 bits on the following 16 edges. o_done pulses for one cycle when o_bcd
// holds the final result, 17 cycles after the i_start cycle. o_bcd holds its
// value until the next start.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   i_start  load i_bin and begin conversion (ignored while busy)
//   i_bin    17-bit binary value (must be <= 99999 to fit five digits)
//   o_busy   conversion in progress
//   o_done   one-cycle pulse, result valid
//   o_bcd    five BCD digits, d4 in [19:16] .. d0 in [3:0]
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [16:0] i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [19:0] o_bcd
);

  logic [16:0] r_bin;
  logic [19:0] r_bcd;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [19:0] w_adj;

  assign w_adj = dd_adjust(r_bcd);

  // Conversion datapath: load + first shift on start, then adjust/shift.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bin  <= 17'd0;
      r_bcd  <= 20'd0;
      r_cnt  <= 5'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_bcd  <= {19'd0, i_bin[16]};
      r_bin  <= {i_bin[15:0], 1'b0};
      r_cnt  <= 5'd16;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_bcd <= {w_adj[18:0], r_bin[16]};
      r_bin <= {r_bin[15:0], 1'b0};
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/score_bitmap_writer.sv
// -----------------------------------------------------------------------------
// score_bitmap_writer
// Renders a binary score into the 1-bit 120x48 score bitmap RAM. On a start
// request the (saturated) score is converted to five BCD digits, then every
// bitmap pixel is filled in raster order from the digit font ROM.
//
// Pipeline per pixel k: oFONT_ADDR carries pixel k after DRAW edge k; the
// registered ROM returns the bit one cycle later, in the same cycle in which
// oWR_EN/oWR_ADDR for pixel k are asserted, so oWR_DATA is the ROM bit gated
// by the write strobe.
//
// Optional feature macro: SCORE_LZ_BLANK_EN -- when defined, leading-zero
// digits (never d0) are written as 0 pixels; write count and timing unchanged.
//
// Ports:
//   iVGA_CLK    clock
//   iRST_n      synchronous active-low reset
//   iSCORE      binary score, sampled when a start is accepted
//   iSTART      render request, only looked at in IDLE
//   oBUSY       render in progress (cleared together with the oDONE pulse)
//   oDONE       one-cycle pulse after the last pixel write is presented
//   oFONT_ADDR  font ROM address (digit*1152 + gy*24 + gx)
//   iFONT_Q     font ROM pixel, 1-cycle read latency
//   oWR_EN      bitmap RAM write strobe
//   oWR_ADDR    bitmap RAM address (py*120 + px)
//   oWR_DATA    bitmap pixel
// -----------------------------------------------------------------------------
module score_bitmap_writer
  import score_pkg::*;
#(
  parameter int DIGITS   = score_pkg::DIGITS,
  parameter int GLYPH_W  = score_pkg::GLYPH_W,
  parameter int GLYPH_H  = score_pkg::GLYPH_H,
  parameter int STRING_W = score_pkg::STRING_W
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [16:0] iSCORE,
  input  logic        iSTART,
  output logic        oBUSY,
  output logic        oDONE,
  output logic [13:0] oFONT_ADDR,
  input  logic        iFONT_Q,
  output logic        oWR_EN,
  output logic [12:0] oWR_ADDR,
  output logic        oWR_DATA
);

  localparam logic [2:0] DIG_LAST = 3'(DIGITS - 1);
  localparam logic [4:0] GX_LAST  = 5'(GLYPH_W - 1);
  localparam logic [5:0] GY_LAST  = 6'(GLYPH_H - 1);

  if (STRING_W != DIGITS * GLYPH_W) begin : g_bad_geometry
    $error("score_bitmap_writer: STRING_W must equal DIGITS*GLYPH_W");
  end

  state_e      r_state;
  state_e      w_next;

  logic        w_start_acc;
  logic [16:0] w_score_sat;
  logic [19:0] w_bcd;
  logic        w_bcd_done;

  logic [2:0]  r_dig;
  logic [4:0]  r_gx;
  logic [5:0]  r_gy;
  logic        w_last_pix;
  logic [3:0]  w_dig_val;
  logic        w_dig_blank;

  logic [13:0] r_font_addr;
  logic        r_fa_valid;
  logic        r_fa_blank;
  logic        r_wr_en;
  logic [12:0] r_wr_addr;
  logic        r_wr_blank;
  logic        r_busy;
  logic        r_done;

  assign w_start_acc = (r_state == ST_IDLE) && iSTART;
  assign w_score_sat = (iSCORE > SCORE_MAX) ? SCORE_MAX : iSCORE;
  assign w_last_pix  = (r_dig == DIG_LAST) && (r_gx == GX_LAST) && (r_gy == GY_LAST);

  bin2bcd_seq u_bin2bcd (
    .i_clk   (iVGA_CLK),
    .i_rst_n (iRST_n),
    .i_start (w_start_acc),
    .i_bin   (w_score_sat),
    .o_busy  (),
    .o_done  (w_bcd_done),
    .o_bcd   (w_bcd)
  );

  // Render FSM state register.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Render FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iSTART) begin
          w_next = ST_CONVERT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (w_bcd_done) begin
          w_next = ST_DRAW;
        end else begin
          w_next = ST_CONVERT;
        end
      end
      ST_DRAW: begin
        if (w_last_pix) begin
          w_next = ST_FLUSH;
        end else begin
          w_next = ST_DRAW;
        end
      end
      ST_FLUSH: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Digit under the scan; string position 0 is the most significant digit.
  always_comb begin
    w_dig_val = 4'd0;
    case (r_dig)
      3'd0:    w_dig_val = w_bcd[19:16];
      3'd1:    w_dig_val = w_bcd[15:12];
      3'd2:    w_dig_val = w_bcd[11:8];
      3'd3:    w_dig_val = w_bcd[7:4];
      3'd4:    w_dig_val = w_bcd[3:0];
      default: w_dig_val = 4'd0;
    endcase
  end

`ifdef SCORE_LZ_BLANK_EN
  logic [3:0] w_lz;

  // w_lz[i]: string positions 0..i are all zero digits. d0 is never blanked.
  always_comb begin
    w_lz[0] = (w_bcd[19:16] == 4'd0);
    w_lz[1] = w_lz[0] && (w_bcd[15:12] == 4'd0);
    w_lz[2] = w_lz[1] && (w_bcd[11:8] == 4'd0);
    w_lz[3] = w_lz[2] && (w_bcd[7:4] == 4'd0);
    w_dig_blank = 1'b0;
    case (r_dig)
      3'd0:    w_dig_blank = w_lz[0];
      3'd1:    w_dig_blank = w_lz[1];
      3'd2:    w_dig_blank = w_lz[2];
      3'd3:    w_dig_blank = w_lz[3];
      default: w_dig_blank = 1'b0;
    endcase
  end
`else
  assign w_dig_blank = 1'b0;
`endif

  // Raster scan counters: gx fastest, then digit, then row. Cleared outside DRAW.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_dig <= 3'd0;
      r_gx  <= 5'd0;
      r_gy  <= 6'd0;
    end else if (r_state == ST_DRAW) begin
      if (r_gx == GX_LAST) begin
        r_gx <= 5'd0;
        if (r_dig == DIG_LAST) begin
          r_dig <= 3'd0;
          r_gy  <= r_gy + 6'd1;
        end else begin
          r_dig <= r_dig + 3'd1;
        end
      end else begin
        r_gx <= r_gx + 5'd1;
      end
    end else begin
      r_dig <= 3'd0;
      r_gx  <= 5'd0;
      r_gy  <= 6'd0;
    end
  end

  // Font address stage: one address per DRAW cycle, blank flag travels along.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_font_addr <= 14'd0;
      r_fa_valid  <= 1'b0;
      r_fa_blank  <= 1'b0;
    end else if (r_state == ST_DRAW) begin
      r_font_addr <= glyph_addr(w_dig_val, r_gy, r_gx);
      r_fa_valid  <= 1'b1;
      r_fa_blank  <= w_dig_blank;
    end else begin
      r_font_addr <= r_font_addr;
      r_fa_valid  <= 1'b0;
      r_fa_blank  <= 1'b0;
    end
  end

  // Write stage, aligned with ROM data; address restarts at 0 for each render.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 13'd0;
      r_wr_blank <= 1'b0;
    end else begin
      r_wr_en    <= r_fa_valid;
      r_wr_blank <= r_fa_blank;
      if (r_fa_valid) begin
        r_wr_addr <= r_wr_en ? (r_wr_addr + 13'd1) : 13'd0;
      end else begin
        r_wr_addr <= 13'd0;
      end
    end
  end

  // Status flags: busy tracks the active states, done marks the FLUSH->DONE step.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == ST_CONVERT) || (w_next == ST_DRAW) || (w_next == ST_FLUSH);
      r_done <= (r_state == ST_FLUSH);
    end
  end

  assign oBUSY      = r_busy;
  assign oDONE      = r_done;
  assign oFONT_ADDR = r_font_addr;
  assign oWR_EN     = r_wr_en;
  assign oWR_ADDR   = r_wr_addr;
  assign oWR_DATA   = r_wr_en & ~r_wr_blank & iFONT_Q;

endmodule

// File: tb/tb_score_bitmap_writer.sv
// -----------------------------------------------------------------------------
// tb_score_bitmap_writer
// Table of {score, expected BCD digits} renders, each checked for latency,
// write count/ordering, first font address and the full bitmap image against
// a behavioural font ROM; plus hand-written sequences for a held start and a
// mid-render reset. Edge numbering: E0 is the edge that accepts the start.
// -----------------------------------------------------------------------------
module tb_score_bitmap_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] score;
  logic        start;
  logic        busy;
  logic        done;
  logic [13:0] font_addr;
  logic        font_q = 1'b0;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic        wr_data;

  always #5 clk = ~clk;

  score_bitmap_writer dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .iSCORE     (score),
    .iSTART     (start),
    .oBUSY      (busy),
    .oDONE      (done),
    .oFONT_ADDR (font_addr),
    .iFONT_Q    (font_q),
    .oWR_EN     (wr_en),
    .oWR_ADDR   (wr_addr),
    .oWR_DATA   (wr_data)
  );

  // Arbitrary but glyph-distinguishing font content.
  function automatic logic font_bit(input logic [13:0] a);
    return a[0] ^ a[2] ^ a[5] ^ a[7] ^ a[11] ^ (a[4] & a[9]);
  endfunction

  // Registered font ROM, 1-cycle latency.
  always @(posedge clk) font_q <= font_bit(font_addr);

  // Bitmap RAM model plus write-ordering monitor.
  logic       ram     [0:5759];
  int         ram_tag [0:5759] = '{default: 0};
  int         cur_tag  = 0;
  int         wr_total = 0;
  int         addr_err = 0;
  logic       prev_en  = 1'b0;
  logic [12:0] prev_addr = 13'd0;

  always @(posedge clk) begin
    prev_en   <= (wr_en === 1'b1);
    prev_addr <= wr_addr;
    if (wr_en === 1'b1) begin
      wr_total <= wr_total + 1;
      if (wr_addr >= 13'd5760 || wr_addr != (prev_en ? prev_addr + 13'd1 : 13'd0))
        addr_err <= addr_err + 1;
      if (wr_addr < 13'd5760) begin
        ram[wr_addr]     <= wr_data;
        ram_tag[wr_addr] <= cur_tag;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected bitmap pixel for a five-digit BCD string.
  function automatic logic exp_pix(input logic [19:0] bcd, input int px, input int py);
    int         dig;
    int         gx;
    logic [3:0] dv;
    logic [13:0] a;
    dig = px / 24;
    gx  = px % 24;
    dv  = bcd[(4-dig)*4 +: 4];
    a   = 14'(int'(dv) * 1152 + py * 24 + gx);
`ifdef SCORE_LZ_BLANK_EN
    begin
      logic lz;
      lz = 1'b1;
      for (int j = 0; j <= dig; j++)
        if (bcd[(4-j)*4 +: 4] != 4'd0) lz = 1'b0;
      if (lz && dig < 4) return 1'b0;
    end
`endif
    return font_bit(a);
  endfunction

  function automatic int image_errors(input logic [19:0] bcd, input int tag);
    int e;
    e = 0;
    for (int py = 0; py < 48; py++)
      for (int px = 0; px < 120; px++)
        if (ram_tag[py*120+px] != tag || ram[py*120+px] !== exp_pix(bcd, px, py)) e++;
    return e;
  endfunction

  // One complete render with start pulsed for a single cycle.
  task automatic run_render(input logic [16:0] sc, input logic [19:0] exp_bcd);
    int done_n, first_n, first_addr, fa0, wr0, aerr0;
    cur_tag    = cur_tag + 1;
    wr0        = wr_total;
    aerr0      = addr_err;
    done_n     = -1;
    first_n    = -1;
    first_addr = -1;
    fa0        = -1;
    score = sc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("busy_after_start[%0d]", sc), int'(busy), 1);
    for (int n = 1; n <= 6000 && done_n < 0; n++) begin
      @(posedge clk); #1;
      if (n == 18) fa0 = int'(font_addr);
      if (wr_en === 1'b1 && first_n < 0) begin
        first_n    = n;
        first_addr = int'(wr_addr);
      end
      if (done === 1'b1) begin
        done_n = n;
        check($sformatf("busy_at_done[%0d]", sc), int'(busy), 0);
      end
    end
    @(posedge clk); #1;
    check($sformatf("done_len[%0d]", sc), int'(done), 0);
    check($sformatf("wr_en_after[%0d]", sc), int'(wr_en), 0);
    check($sformatf("wr_addr_after[%0d]", sc), int'(wr_addr), 0);
    check($sformatf("done_edge[%0d]", sc), done_n, 5778);
    check($sformatf("first_wr_edge[%0d]", sc), first_n, 19);
    check($sformatf("first_wr_addr[%0d]", sc), first_addr, 0);
    check($sformatf("font_addr_px0[%0d]", sc), fa0, int'(exp_bcd[19:16]) * 1152);
    check($sformatf("wr_count[%0d]", sc), wr_total - wr0, 5760);
    check($sformatf("wr_order[%0d]", sc), addr_err - aerr0, 0);
    check($sformatf("image[%0d]", sc), image_errors(exp_bcd, cur_tag), 0);
  endtask

  typedef struct {
    logic [16:0] sc;
    logic [19:0] bcd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int wr0, aerr0, done_cnt, first_done, second_done, busy_5779, busy_5780, done_5779;
    int hit;

    // Saturation uses 100000 and 131071: 200000 does not fit the 17-bit port.
    vecs[0] = '{17'd12345,  20'h12345};
    vecs[1] = '{17'd131071, 20'h99999};
    vecs[2] = '{17'd42,     20'h00042};
    vecs[3] = '{17'd0,      20'h00000};
    vecs[4] = '{17'd99999,  20'h99999};
    vecs[5] = '{17'd100000, 20'h99999};

    rst_n = 1'b0;
    start = 1'b0;
    score = 17'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      int'(busy),      0);
    check("rst_done",      int'(done),      0);
    check("rst_wr_en",     int'(wr_en),     0);
    check("rst_wr_addr",   int'(wr_addr),   0);
    check("rst_wr_data",   int'(wr_data),   0);
    check("rst_font_addr", int'(font_addr), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_render(vecs[i].sc, vecs[i].bcd);
      repeat (2) @(posedge clk);
      #1;
    end

    // iSTART held through a whole render: one done, then an immediate restart.
    cur_tag  = cur_tag + 1;
    wr0      = wr_total;
    aerr0    = addr_err;
    done_cnt = 0;
    first_done  = -1;
    second_done = -1;
    busy_5779 = -1;
    busy_5780 = -1;
    done_5779 = -1;
    score = 17'd12345;
    start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 12000 && second_done < 0; n++) begin
      @(posedge clk); #1;
      if (n == 5779) begin
        busy_5779 = int'(busy);
        done_5779 = int'(done);
      end
      if (n == 5780) begin
        busy_5780 = int'(busy);
        start = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = n;
        else second_done = n;
      end
    end
    @(posedge clk); #1;
    check("hold_first_done",  first_done,  5778);
    check("hold_idle_busy",   busy_5779,   0);
    check("hold_idle_done",   done_5779,   0);
    check("hold_restart",     busy_5780,   1);
    check("hold_second_done", second_done, 5780 + 5778);
    check("hold_done_count",  done_cnt,    2);
    check("hold_wr_count",    wr_total - wr0, 11520);
    check("hold_wr_order",    addr_err - aerr0, 0);
    check("hold_image",       image_errors(20'h12345, cur_tag), 0);

    // Reset while write 3000 is on the bus.
    cur_tag = cur_tag + 1;
    wr0     = wr_total;
    hit     = 0;
    score   = 17'd54321;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 6000 && hit == 0; n++) begin
      @(posedge clk); #1;
      if (wr_en === 1'b1 && wr_addr == 13'd3000) hit = 1;
    end
    check("rst_mid_reached", hit, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_wr_en",     int'(wr_en),     0);
    check("rst_mid_busy",      int'(busy),      0);
    check("rst_mid_done",      int'(done),      0);
    check("rst_mid_wr_addr",   int'(wr_addr),   0);
    check("rst_mid_wr_data",   int'(wr_data),   0);
    check("rst_mid_font_addr", int'(font_addr), 0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rst_mid_wr_count",  wr_total - wr0, 3001);
    check("rst_mid_idle_busy", int'(busy), 0);
    check("rst_mid_partial",   int'(ram_tag[3001] != cur_tag && ram_tag[3000] == cur_tag), 1);
    run_render(17'd777, 20'h00777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
